// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: single-outstanding req/gnt/valid handshake,
// one-entry buffer across decode stalls, and execute-stage redirect handling.
//
// state | meaning
// RST   | just out of reset, no request yet
// REQ   | request asserted at pc, waiting for grant
// WAIT  | request granted, waiting for response data
// HOLD  | response buffered while decode is stalled
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_VALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        STALL_D,
  input  logic        BRANCH_E,
  input  logic [31:0] TARGET_E,
  output logic [31:0] INST_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC4_F,
  output logic        EN_D,
  output logic        CLR_D
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] buf_q, buf_d;
  logic        kill_q, kill_d;

  logic        avail;
  logic [31:0] fpc_inc;

  assign fpc_inc = fpc_q + 32'd4;
  assign avail   = ((state_q == ST_WAIT) && IMEM_VALID && !kill_q) ||
                   (state_q == ST_HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      fpc_q  <= RESET_PC;
      buf_q  <= NOP_INST;
      kill_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      fpc_q  <= fpc_d;
      buf_q  <= buf_d;
      kill_q <= kill_d;
    end
  end

  // A redirect takes priority over stall and delivery in every state but RST.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fpc_d   = fpc_q;
    buf_d   = buf_q;
    kill_d  = kill_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (BRANCH_E) begin
          pc_d = TARGET_E;
        end
        if (IMEM_GNT) begin
          fpc_d   = pc_q;
          kill_d  = BRANCH_E;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (BRANCH_E) begin
          pc_d = TARGET_E;
          if (IMEM_VALID) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (IMEM_VALID) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else if (!STALL_D) begin
            pc_d    = fpc_inc;
            state_d = ST_REQ;
          end else begin
            buf_d   = IMEM_RDATA;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (BRANCH_E) begin
          pc_d    = TARGET_E;
          state_d = ST_REQ;
        end else if (!STALL_D) begin
          pc_d    = fpc_inc;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  always_comb begin
    IMEM_REQ  = (state_q == ST_REQ);
    IMEM_ADDR = pc_q;
    PC_F      = fpc_q;
    PC4_F     = fpc_inc;
    INST_F    = NOP_INST;
    if (avail) begin
      INST_F = (state_q == ST_HOLD) ? buf_q : IMEM_RDATA;
    end
    EN_D  = 1'b0;
    CLR_D = 1'b0;
    // Decode controls stay idle until the first request; a bubble is
    // inserted whenever decode is free but fetch has nothing to give.
    if (state_q != ST_RST) begin
      EN_D  = !STALL_D || BRANCH_E;
      CLR_D = BRANCH_E || (!STALL_D && !avail);
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the pipelined RV32I core. It runs a single-outstanding request/grant/valid handshake to instruction memory, tracks the fetch PC, and buffers one returned instruction across decode stalls. It drives the F-stage values (INST_F, PC_F, PC4_F) together with the enable and clear controls of the IF/ID pipeline register. It applies execute-stage redirects, discarding wrong-path responses and flushing decode.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, instruction presented on INST_F when no valid instruction exists
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- IMEM_REQ  out  1  fetch request to instruction memory
- IMEM_ADDR  out  32  fetch address, valid while IMEM_REQ=1
- IMEM_GNT  in  1  memory accepts the request this cycle
- IMEM_VALID  in  1  response data valid (earliest: cycle after grant)
- IMEM_RDATA  in  32  instruction word
- STALL_D  in  1  hazard unit holds the decode stage
- BRANCH_E  in  1  taken branch/jump resolved in execute
- TARGET_E  in  32  redirect target
- INST_F  out  32  instruction to the IF/ID register
- PC_F  out  32  address of INST_F
- PC4_F  out  32  PC_F+4, modulo 2^32
- EN_D  out  1  IF/ID load enable
- CLR_D  out  1  IF/ID synchronous clear, wins over EN_D

## Operation
- State: pc (next fetch address), fpc (address of the buffered or in-flight instruction), buf (32-bit instruction buffer), kill (1-bit flag), FSM.
- FSM states: RST, REQ, WAIT, HOLD.
- RST: entered on reset. Always moves to REQ on the next clock.
- REQ:
  - IMEM_REQ=1, IMEM_ADDR=pc.
  - On IMEM_GNT: fpc<=pc, go to WAIT.
- WAIT: IMEM_REQ=0. On IMEM_VALID:
  - kill=1: drop the data, clear kill, go to REQ.
  - kill=0, STALL_D=0: deliver IMEM_RDATA, pc<=fpc+4, go to REQ.
  - kill=0, STALL_D=1: buf<=IMEM_RDATA, go to HOLD.
- HOLD: presents buf. When STALL_D=0: deliver, pc<=fpc+4, go to REQ.
- "Instruction available" (avail) means WAIT with IMEM_VALID=1 and kill=0, or HOLD.
  - INST_F = IMEM_RDATA in WAIT, buf in HOLD, NOP_INST otherwise.
  - PC_F = fpc.
- Decode control:
  - EN_D = !STALL_D | BRANCH_E.
  - CLR_D = BRANCH_E | (!STALL_D & !avail). Decode receives a bubble when fetch has nothing to give.
- Redirect (BRANCH_E=1) overrides stall and delivery in every state. It sets CLR_D=1, pc<=TARGET_E, and nothing is delivered that cycle.
  - REQ without grant: next request uses TARGET_E.
  - REQ with grant: go to WAIT with kill<=1.
  - WAIT without IMEM_VALID: kill<=1.
  - WAIT with IMEM_VALID: drop the response, go to REQ.
  - HOLD: discard buf, go to REQ.
- Redirect during RST is ignored.
- TARGET_E is used unmodified; alignment is the responsibility of execute.

## Timing
- Reset values: IMEM_REQ=0, IMEM_ADDR=RESET_PC, INST_F=NOP_INST, PC_F=RESET_PC, PC4_F=RESET_PC+4, EN_D=0, CLR_D=0, kill=0, pc=fpc=RESET_PC.
- Reset may assert mid-transaction. All state clears immediately. A later IMEM_VALID for the abandoned request is ignored because the FSM is not in WAIT.
- First IMEM_REQ: first clk edge after reset release.
- Zero-wait memory (grant in REQ, valid on the next cycle): one instruction every 2 cycles. Latency from grant to INST_F valid is 1 cycle plus memory wait cycles.
- At most one request outstanding. IMEM_REQ is never asserted in WAIT or HOLD.
- IMEM_ADDR is stable while IMEM_REQ=1 and IMEM_GNT=0, unless a redirect occurs.
- A branch on the same cycle as IMEM_VALID beats delivery. A branch on the same cycle as IMEM_GNT produces exactly one killed response.
- pc+4 wraps from 32'hFFFF_FFFC to 0.

## Test plan
- Reset release, memory grants immediately and returns 0x00500093 next cycle:
  - IMEM_ADDR=0x0.
  - INST_F=0x00500093, PC_F=0, PC4_F=4, EN_D=1.
  - Next request address is 0x4.
- Delivery under stall: STALL_D=1 for 3 cycles on the IMEM_VALID cycle.
  - FSM goes to HOLD and INST_F holds the word; EN_D=0, CLR_D=0 throughout.
  - Delivery occurs on the cycle STALL_D falls, and the next IMEM_ADDR is fpc+4.
- Redirect while waiting: BRANCH_E=1 with TARGET_E=0x100 in WAIT, IMEM_VALID arrives 2 cycles later.
  - CLR_D=1 on the branch cycle.
  - The response is dropped: CLR_D=1, INST_F=NOP_INST.
  - Next IMEM_ADDR=0x100.
- Same-cycle BRANCH_E and IMEM_GNT:
  - Exactly one response is discarded.
  - The following fetch is to TARGET_E.
- Branch with STALL_D=1 in HOLD:
  - EN_D=1, CLR_D=1, buf is discarded.
  - Next IMEM_ADDR=TARGET_E.
- Wrap and mid-flight reset:
  - Fetch at 0xFFFF_FFFC: PC4_F=0, next address 0x0.
  - Assert reset in WAIT: outputs return to their reset values asynchronously, and a late IMEM_VALID produces no delivery.
